// File: rtl/knn_feeder_pkg.sv
// Shared types for the KNN feeder: FSM state encoding, result word layout
// and a counter-width helper.
package knn_feeder_pkg;

    // Sequencer phases, exported on the debug port as-is.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_T = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_READ   = 3'd4,
        S_FIN    = 3'd5
    } state_t;

    localparam int RES_DATA_W = 8;
    localparam int RES_IDX_W  = 4;

    // One result word as carried on the result stream.
    typedef struct packed {
        logic [RES_DATA_W-1:0] data;
        logic [RES_IDX_W-1:0]  tp;
        logic [RES_IDX_W-1:0]  rank;
    } res_word_t;

    // Counter width for a count bound, never narrower than one bit.
    function automatic int cnt_w(input int bound);
        return (bound > 1) ? $clog2(bound) : 1;
    endfunction

endpackage

// File: rtl/knn_feeder_if.sv
// Result stream from the feeder to its consumer.
// Handshake: a word transfers on every rising clock edge where res_valid and
// res_ready are both high; once res_valid is raised, the producer holds
// res_valid, res_data, res_tp and res_rank stable until that transfer, and
// res_valid never waits on res_ready.
interface knn_feeder_if;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [3:0] res_tp;
    logic [3:0] res_rank;

    modport master (
        output res_valid,
        output res_data,
        output res_tp,
        output res_rank,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_data,
        input  res_tp,
        input  res_rank,
        output res_ready
    );
endinterface

// File: rtl/knn_res_reg.sv
// Single-entry valid/ready output register for result words. A load is only
// issued when the slot is empty or being drained in the same cycle, so the
// held word never changes under backpressure.
module knn_res_reg
    import knn_feeder_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      load,
    input  res_word_t load_word,
    input  logic      ready,
    output logic      valid,
    output res_word_t word
);

    // Fill on load, empty on an accept with no refill, otherwise hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            word  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            word  <= load_word;
        end else if (valid && ready) begin
            valid <= 1'b0;
            word  <= '0;
        end
    end

endmodule

// File: rtl/knn_feeder.sv
// KNN feeder: for each test point, read it from point memory, stream every
// data point against it into the core, wait out the core's list latency,
// then read the core's result list and emit it on the result stream.
module knn_feeder
    import knn_feeder_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NBR_KNN   = 4,   // 1..16
    parameter int NBR_TESTP = 4,   // 1..16
    parameter int NBR_DATAP = 10,
    parameter int ADDR_W    = 8,
    parameter int DRAIN     = 3    // at least 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              core_en,
    output logic              core_valid,
    output logic              core_ready,
    output logic [DATA_W-1:0] core_a,
    output logic [DATA_W-1:0] core_b,
    output logic [3:0]        knn_id,
    input  logic [7:0]        knn_info,
    knn_feeder_if.master      res,
    output state_t            dbg_state
);

    localparam int TP_W = cnt_w(NBR_TESTP);
    // dp runs one past the last data point: the extra STREAM cycle presents
    // the final read's data while no new read is issued.
    localparam int DP_W = cnt_w(NBR_DATAP + 1);
    localparam int DR_W = cnt_w(DRAIN);
    localparam int KN_W = cnt_w(NBR_KNN);

    localparam logic [TP_W-1:0]   TP_LAST  = TP_W'(NBR_TESTP - 1);
    localparam logic [DP_W-1:0]   DP_LAST  = DP_W'(NBR_DATAP);
    localparam logic [DR_W-1:0]   DR_LAST  = DR_W'(DRAIN - 1);
    localparam logic [KN_W-1:0]   KID_LAST = KN_W'(NBR_KNN - 1);
    localparam logic [ADDR_W-1:0] DP_BASE  = ADDR_W'(NBR_TESTP);

    state_t          state, state_n;
    logic [TP_W-1:0] tp, tp_n;
    logic [DP_W-1:0] dp, dp_n;
    logic [DR_W-1:0] dr, dr_n;
    logic [KN_W-1:0] kid, kid_n;   // rank currently held in the result register

    logic      a_load;
    logic      res_load;
    logic      accept;
    logic      res_valid_q;
    res_word_t res_word_q;
    res_word_t load_word;

    assign accept = res_valid_q & res.res_ready;

    // State, counters and the held test point.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            tp     <= '0;
            dp     <= '0;
            dr     <= '0;
            kid    <= '0;
            core_a <= '0;
        end else begin
            state <= state_n;
            tp    <= tp_n;
            dp    <= dp_n;
            dr    <= dr_n;
            kid   <= kid_n;
            if (a_load) begin
                core_a <= mem_rdata;
            end
        end
    end

    // Next-state and counter stepping; also decides when the result register loads.
    always_comb begin
        state_n  = state;
        tp_n     = tp;
        dp_n     = dp;
        dr_n     = dr;
        kid_n    = kid;
        res_load = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_LOAD_T;
                    tp_n    = '0;
                end
            end
            S_LOAD_T: begin
                state_n = S_STREAM;
                dp_n    = '0;
            end
            S_STREAM: begin
                if (dp == DP_LAST) begin
                    state_n = S_DRAIN;
                    dp_n    = '0;
                    dr_n    = '0;
                end else begin
                    dp_n = dp + 1'b1;
                end
            end
            S_DRAIN: begin
                // The last drain cycle already fetches rank 0 so READ
                // starts with a valid word.
                if (dr == DR_LAST) begin
                    state_n  = S_READ;
                    dr_n     = '0;
                    kid_n    = '0;
                    res_load = 1'b1;
                end else begin
                    dr_n = dr + 1'b1;
                end
            end
            S_READ: begin
                if (accept) begin
                    if (kid == KID_LAST) begin
                        kid_n = '0;
                        if (tp == TP_LAST) begin
                            state_n = S_FIN;
                            tp_n    = '0;
                        end else begin
                            state_n = S_LOAD_T;
                            tp_n    = tp + 1'b1;
                        end
                    end else begin
                        kid_n    = kid + 1'b1;
                        res_load = 1'b1;
                    end
                end
            end
            S_FIN: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Memory, core-side and status outputs decoded from state and counters.
    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        mem_rd     = 1'b0;
        mem_addr   = '0;
        core_valid = 1'b0;
        core_ready = 1'b0;
        core_b     = '0;
        knn_id     = '0;
        a_load     = 1'b0;
        case (state)
            S_LOAD_T: begin
                busy     = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = ADDR_W'(tp);
            end
            S_STREAM: begin
                busy   = 1'b1;
                // First STREAM cycle carries the test point read in LOAD_T.
                a_load = (dp == '0);
                if (dp != DP_LAST) begin
                    mem_rd   = 1'b1;
                    mem_addr = DP_BASE + ADDR_W'(dp);
                end
                if (dp != '0) begin
                    core_valid = 1'b1;
                    core_b     = mem_rdata;
                end
                core_ready = (dp == DP_LAST);
            end
            S_DRAIN: begin
                busy = 1'b1;
            end
            S_READ: begin
                busy = 1'b1;
                // Look one rank ahead so the next word is ready on accept.
                if (kid != KID_LAST) begin
                    knn_id = 4'(kid + 1'b1);
                end
            end
            S_FIN: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign core_en   = busy;
    assign dbg_state = state;

    assign load_word = '{data: knn_info, tp: 4'(tp), rank: knn_id};

    knn_res_reg u_res_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (res_load),
        .load_word (load_word),
        .ready     (res.res_ready),
        .valid     (res_valid_q),
        .word      (res_word_q)
    );

    assign res.res_valid = res_valid_q;
    assign res.res_data  = res_word_q.data;
    assign res.res_tp    = res_word_q.tp;
    assign res.res_rank  = res_word_q.rank;

endmodule

// File: tb/tb_knn_feeder.sv
// Bench for knn_feeder: memory and core result models, a reference model
// filling expected queues per run, and a monitor draining them.
module tb_knn_feeder;
  import knn_feeder_pkg::*;

  localparam int DATA_W = 32;
  localparam int NK     = 4;
  localparam int NT     = 4;
  localparam int ND     = 10;
  localparam int ADDR_W = 8;
  localparam int DR     = 3;
  localparam int NMEM   = NT + ND;
  localparam int PER_TP = 2 + ND + DR + NK;
  localparam int LIMIT  = 3000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- main DUT ----------------
  logic              start = 1'b0;
  logic              busy, done, mem_rd, core_en, core_valid, core_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [DATA_W-1:0] core_a, core_b;
  logic [3:0]        knn_id;
  logic [7:0]        knn_info;
  state_t            m_state;
  knn_feeder_if      m_if ();

  knn_feeder #(.DATA_W(DATA_W), .NBR_KNN(NK), .NBR_TESTP(NT), .NBR_DATAP(ND),
               .ADDR_W(ADDR_W), .DRAIN(DR)) u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .core_en(core_en), .core_valid(core_valid), .core_ready(core_ready),
    .core_a(core_a), .core_b(core_b), .knn_id(knn_id), .knn_info(knn_info),
    .res(m_if.master), .dbg_state(m_state)
  );

  logic [DATA_W-1:0] mem [0:NMEM-1];
  logic [7:0]        lut [0:15][0:15];
  int                ready_cnt = 0;
  logic [3:0]        info_tp;

  always @(posedge clk)
    if (mem_rd) mem_rdata <= (int'(mem_addr) < NMEM) ? mem[mem_addr] : 32'hdead_beef;

  // core result list: depends on which test point the core last finished
  assign info_tp  = (ready_cnt == 0) ? 4'd0 : 4'(ready_cnt - 1);
  assign knn_info = lut[info_tp][knn_id];

  // ---------------- small DUT (1 test point, 1 data point) ----------------
  logic              s_start = 1'b0;
  logic              s_busy, s_done, s_mem_rd, s_core_en, s_core_valid, s_core_ready;
  logic [ADDR_W-1:0] s_mem_addr;
  logic [DATA_W-1:0] s_mem_rdata = '0;
  logic [DATA_W-1:0] s_core_a, s_core_b;
  logic [3:0]        s_knn_id;
  logic [7:0]        s_knn_info;
  state_t            s_state;
  knn_feeder_if      s_if ();
  logic [DATA_W-1:0] s_mem [0:1];
  logic [7:0]        s_lut [0:15];

  knn_feeder #(.DATA_W(DATA_W), .NBR_KNN(NK), .NBR_TESTP(1), .NBR_DATAP(1),
               .ADDR_W(ADDR_W), .DRAIN(DR)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done),
    .mem_addr(s_mem_addr), .mem_rd(s_mem_rd), .mem_rdata(s_mem_rdata),
    .core_en(s_core_en), .core_valid(s_core_valid), .core_ready(s_core_ready),
    .core_a(s_core_a), .core_b(s_core_b), .knn_id(s_knn_id), .knn_info(s_knn_info),
    .res(s_if.master), .dbg_state(s_state)
  );

  always @(posedge clk)
    if (s_mem_rd) s_mem_rdata <= (int'(s_mem_addr) < 2) ? s_mem[s_mem_addr[0]] : 32'hdead_beef;
  assign s_knn_info = s_lut[s_knn_id];

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [64:0] exp_core_q[$];   // {core_a, core_b, core_ready}
  logic [15:0] exp_res_q[$];    // {data, tp, rank}
  int done_cnt = 0;
  int res_cnt  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ctl"}, {busy, done, mem_rd, core_en, core_valid, core_ready, knn_id,
                          m_if.res_valid, m_if.res_data, m_if.res_tp, m_if.res_rank}, 64'd0);
    check({tag, "_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_core_a"}, 64'(core_a), 64'd0);
    check({tag, "_core_b"}, 64'(core_b), 64'd0);
    check({tag, "_state"}, 64'(m_state), 64'(S_IDLE));
  endtask

  // reference model: what one full run must produce, in order
  task automatic model_run();
    for (int t = 0; t < NT; t++) begin
      for (int d = 0; d < ND; d++)
        exp_core_q.push_back({mem[t], mem[NT + d], (d == ND - 1)});
      for (int r = 0; r < NK; r++)
        exp_res_q.push_back({lut[t][r], 4'(t), 4'(r)});
    end
  endtask

  // monitor: sample mid-cycle, after the drivers have settled
  initial begin
    logic [64:0] ec;
    logic [15:0] er;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [15:0] prev_word  = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        prev_valid = 1'b0;
      end else begin
        if (core_ready) check("core_ready_qual", 64'(core_valid), 64'd1);
        if (mem_rd) check("mem_addr_range", 64'(int'(mem_addr) < NMEM), 64'd1);
        if (core_valid) begin
          if (exp_core_q.size() == 0) begin
            total++; bad++;
            $display("FAIL core_extra: got core_b=0x%0h, expected no core_valid", core_b);
          end else begin
            ec = exp_core_q.pop_front();
            check("core_a", 64'(core_a), 64'(ec[64:33]));
            check("core_b", 64'(core_b), 64'(ec[32:1]));
            check("core_ready", 64'(core_ready), 64'(ec[0]));
          end
        end
        if (core_ready) ready_cnt++;
        if (prev_valid && !prev_ready) begin
          check("hold_valid", 64'(m_if.res_valid), 64'd1);
          check("hold_word", 64'({m_if.res_data, m_if.res_tp, m_if.res_rank}), 64'(prev_word));
        end
        if (m_if.res_valid && m_if.res_ready) begin
          res_cnt++;
          if (exp_res_q.size() == 0) begin
            total++; bad++;
            $display("FAIL res_extra: got rank %0d tp %0d, expected no result", m_if.res_rank, m_if.res_tp);
          end else begin
            er = exp_res_q.pop_front();
            check("res_data", 64'(m_if.res_data), 64'(er[15:8]));
            check("res_tp", 64'(m_if.res_tp), 64'(er[7:4]));
            check("res_rank", 64'(m_if.res_rank), 64'(er[3:0]));
          end
        end
        if (done) done_cnt++;
        prev_valid = m_if.res_valid;
        prev_ready = m_if.res_ready;
        prev_word  = {m_if.res_data, m_if.res_tp, m_if.res_rank};
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill_lut();
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        lut[i][j] = 8'($urandom);
  endtask

  task automatic fill_mem_random();
    for (int i = 0; i < NMEM; i++) mem[i] = $urandom;
  endtask

  // mode 0: res_ready=1; 1: backpressure; 2: extra start while busy; 3: reset mid-stream
  task automatic run_main(input int mode);
    int cyc;
    int done0;
    int res0;
    model_run();
    done0 = done_cnt;
    res0  = res_cnt;
    m_if.res_ready = 1'b1;
    @(negedge clk);
    ready_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    check("busy_after_start", 64'(busy), 64'd1);
    check("core_en_after_start", 64'(core_en), 64'd1);
    while (!done && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      if (mode == 1)
        m_if.res_ready = (cyc >= 17 && cyc < 22) ? 1'b0 : ($urandom_range(0, 3) != 0);
      start = (mode == 2 && cyc == 30);
      if (mode == 3 && cyc == 8) begin
        #2 rst = 1'b0;
        #1 check_idle("async_rst");
        break;
      end
    end
    start = 1'b0;
    if (mode == 3) begin
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      exp_core_q.delete();
      exp_res_q.delete();
      @(negedge clk);
      check_idle("after_rst");
      return;
    end
    if (cyc >= LIMIT) begin
      total++; bad++;
      $display("FAIL run_timeout: got no done in %0d cycles, expected done", cyc);
    end
    if (mode == 0) check("cycles_to_done", 64'(cyc), 64'(NT * PER_TP + 1));
    repeat (5) @(negedge clk);
    m_if.res_ready = 1'b1;
    check("done_count", 64'(done_cnt - done0), 64'd1);
    check("result_count", 64'(res_cnt - res0), 64'(NT * NK));
    check("core_q_empty", 64'(exp_core_q.size()), 64'd0);
    check("res_q_empty", 64'(exp_res_q.size()), 64'd0);
    check("busy_after_done", 64'(busy), 64'd0);
  endtask

  task automatic run_small();
    int cyc;
    int nv;
    int nr;
    int nd;
    s_mem[0] = $urandom;
    s_mem[1] = $urandom;
    for (int i = 0; i < 16; i++) s_lut[i] = 8'($urandom);
    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    cyc = 1; nv = 0; nr = 0; nd = 0;
    while (cyc < 200) begin
      if (s_core_valid) begin
        nv++;
        check("s_core_a", 64'(s_core_a), 64'(s_mem[0]));
        check("s_core_b", 64'(s_core_b), 64'(s_mem[1]));
        check("s_core_ready", 64'(s_core_ready), 64'd1);
      end
      if (s_if.res_valid) begin
        check("s_res_data", 64'(s_if.res_data), 64'(s_lut[nr % 16]));
        check("s_res_tp", 64'(s_if.res_tp), 64'd0);
        check("s_res_rank", 64'(s_if.res_rank), 64'(nr));
        nr++;
      end
      if (s_done) begin
        nd++;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    check("s_done_seen", 64'(nd), 64'd1);
    check("s_valid_count", 64'(nv), 64'd1);
    check("s_result_count", 64'(nr), 64'(NK));
    check("s_cycles", 64'(cyc), 64'(2 + 1 + DR + NK + 1));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    m_if.res_ready = 1'b0;
    s_if.res_ready = 1'b1;
    for (int i = 0; i < NT; i++) mem[i] = 32'(i + 1);
    for (int j = 0; j < ND; j++) mem[NT + j] = 32'(j * 3);
    fill_lut();
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    check("s_reset_ctl", 64'({s_busy, s_done, s_mem_rd, s_core_valid, s_if.res_valid}), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    run_main(0);
    fill_mem_random(); fill_lut();
    run_main(1);
    fill_mem_random(); fill_lut();
    run_main(2);
    fill_mem_random(); fill_lut();
    run_main(3);
    run_main(0);
    run_small();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
